matrix_link_master: RTL and testbench



---
 rtl/matrix_link_master.sv | 164 ++++++++++++++++
 tb/tb_matrix_link_master.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_link_master.sv
// Initiator side of the 32-bit matrix link: streams operands A/B to the control unit
// over a toggle handshake, collects 25 result bytes, then flushes the unit back to idle.
module matrix_link_master #(
   parameter int START_HOLD = 4,
   parameter int SETTLE     = 3,
   parameter int TIMEOUT    = 65535
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        wr_en,
   input  logic [4:0]  wr_addr,
   input  logic [7:0]  wr_a,
   input  logic [7:0]  wr_b,
   input  logic [2:0]  op_code,
   input  logic [1:0]  matrix_size,
   input  logic        go,
   input  logic        abort,
   input  logic [4:0]  rd_addr,
   output logic [7:0]  rd_data,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] link_out,
   input  logic [31:0] link_in
);

   typedef enum logic [3:0] {
      IDLE, START, TX_RAISE, TX_DROP, RX_RAISE, RX_DROP, RX_SETTLE,
      FLUSH_RAISE, FLUSH_DROP, DONE, ERROR, ABORT
   } state_t;

   state_t      state, state_nxt;
   logic [4:0]  idx, idx_nxt;
   logic [31:0] timer, timer_nxt;
   logic [2:0]  op_q, op_nxt;
   logic [1:0]  size_q, size_nxt;
   logic        err_nxt, res_we, timed_out;
   logic [1:0]  ack_s;
   logic        ack;
   logic [31:0] link_nxt;

   logic [7:0]  a_mem   [0:24];
   logic [7:0]  b_mem   [0:24];
   logic [7:0]  res_mem [0:24];

   logic unused_in;
   assign unused_in = ^link_in[30:8];

   assign ack  = ack_s[1];
   assign busy = !(state inside {IDLE, DONE, ERROR});
   assign done = (state == DONE);
   assign timed_out = (TIMEOUT != 0) && (timer == 32'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      op_nxt    = op_q;
      size_nxt  = size_q;
      err_nxt   = error;
      res_we    = 1'b0;
      case (state)
         IDLE, ERROR: if (go) begin
            op_nxt    = op_code;
            size_nxt  = matrix_size;
            err_nxt   = 1'b0;
            idx_nxt   = '0;
            state_nxt = START;
         end
         START:       if (timer == 32'(START_HOLD - 1)) state_nxt = TX_RAISE;
         TX_RAISE:    if (ack) state_nxt = TX_DROP;
                      else if (timed_out) state_nxt = ERROR;
         TX_DROP:     if (!ack) begin
            if (idx == 5'd24) begin
               idx_nxt   = '0;
               state_nxt = RX_RAISE;
            end else begin
               idx_nxt   = idx + 5'd1;
               state_nxt = TX_RAISE;
            end
         end else if (timed_out) state_nxt = ERROR;
         RX_RAISE:    if (ack) state_nxt = RX_DROP;
                      else if (timed_out) state_nxt = ERROR;
         RX_DROP:     if (!ack) state_nxt = RX_SETTLE;
                      else if (timed_out) state_nxt = ERROR;
         // data byte has been stable since before ack fell; sample after SETTLE cycles
         RX_SETTLE:   if (timer == 32'(SETTLE - 1)) begin
            res_we = 1'b1;
            if (idx == 5'd24) begin
               idx_nxt   = '0;
               state_nxt = FLUSH_RAISE;
            end else begin
               idx_nxt   = idx + 5'd1;
               state_nxt = RX_RAISE;
            end
         end
         FLUSH_RAISE: if (ack) state_nxt = FLUSH_DROP;
                      else if (timed_out) state_nxt = ERROR;
         FLUSH_DROP:  if (!ack) state_nxt = DONE;
                      else if (timed_out) state_nxt = ERROR;
         DONE:        state_nxt = IDLE;
         ABORT:       if (timer == 32'd1) state_nxt = IDLE;
         default:     state_nxt = IDLE;
      endcase
      if (state_nxt == ERROR && state != ERROR) err_nxt = 1'b1;
      if (abort) begin
         state_nxt = ABORT;
         err_nxt   = 1'b0;
         idx_nxt   = '0;
         res_we    = 1'b0;
      end
      timer_nxt = (abort || state_nxt != state) ? '0 : timer + 32'd1;
   end

   // link_out is built from next-state values so the registered word tracks the state
   always_comb begin
      link_nxt = '0;
      case (state_nxt)
         START:                         link_nxt[30] = 1'b1;
         TX_RAISE, RX_RAISE, FLUSH_RAISE: link_nxt[31] = 1'b1;
         ABORT:                         link_nxt[29] = 1'b1;
         default: ;
      endcase
      if (state_nxt inside {TX_RAISE, TX_DROP}) begin
         link_nxt[7:0]  = a_mem[idx_nxt];
         link_nxt[15:8] = b_mem[idx_nxt];
      end
      if (state_nxt inside {START, TX_RAISE, TX_DROP, RX_RAISE, RX_DROP, RX_SETTLE,
                            FLUSH_RAISE, FLUSH_DROP})
         link_nxt[20:16] = {size_nxt, op_nxt};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         idx      <= '0;
         timer    <= '0;
         op_q     <= '0;
         size_q   <= '0;
         error    <= 1'b0;
         ack_s    <= '0;
         link_out <= '0;
         rd_data  <= '0;
      end else begin
         state    <= state_nxt;
         idx      <= idx_nxt;
         timer    <= timer_nxt;
         op_q     <= op_nxt;
         size_q   <= size_nxt;
         error    <= err_nxt;
         ack_s    <= {ack_s[0], link_in[31]};
         link_out <= link_nxt;
         rd_data  <= (rd_addr < 5'd25) ? res_mem[rd_addr] : 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && wr_addr < 5'd25) begin
         a_mem[wr_addr] <= wr_a;
         b_mem[wr_addr] <= wr_b;
      end
      if (res_we) res_mem[idx] <= link_in[7:0];
   end

endmodule

// File: tb/tb_matrix_link_master.sv
// Bench for matrix_link_master against a behavioural control-unit model that returns A+B.
module tb_matrix_link_master;
   localparam int TO = 6000;

   logic        clk = 1'b0, reset_n = 1'b0;
   logic        wr_en = 1'b0, go = 1'b0, abort = 1'b0;
   logic [4:0]  wr_addr = '0, rd_addr = '0;
   logic [7:0]  wr_a = '0, wr_b = '0, rd_data;
   logic [2:0]  op_code = 3'd3;
   logic [1:0]  matrix_size = 2'd2;
   logic        busy, done, error;
   logic [31:0] link_out, link_in;

   matrix_link_master #(.START_HOLD(4), .SETTLE(3), .TIMEOUT(TO)) dut (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a),
      .wr_b(wr_b), .op_code(op_code), .matrix_size(matrix_size), .go(go), .abort(abort),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .error(error),
      .link_out(link_out), .link_in(link_in)
   );

   always #5 clk = ~clk;

   // control-unit model: handshake counter hs, 0-24 TX, 25-49 RX, 50 flush
   int         hs = 0, wcnt = 0, proc_delay = 10, stall_hs = 99, done_cnt = 0;
   logic       m_ack = 1'b0;
   logic [7:0] m_data = '0;
   logic [7:0] ma [25];
   logic [7:0] mb [25];
   assign link_in = {m_ack, 23'd0, m_data};

   always @(posedge clk) begin
      if (link_out[29] || link_out[30]) begin
         hs <= 0; m_ack <= 1'b0; wcnt <= 0;
      end else if (!m_ack) begin
         if (link_out[31] && hs != stall_hs) begin
            if (wcnt >= ((hs == 25) ? proc_delay : 2)) begin
               m_ack <= 1'b1; wcnt <= 0;
               if (hs < 25) begin
                  ma[hs] <= link_out[7:0];
                  mb[hs] <= link_out[15:8];
               end else if (hs < 50) m_data <= ma[hs-25] + mb[hs-25];
            end else wcnt <= wcnt + 1;
         end
      end else if (!link_out[31]) begin
         m_ack <= 1'b0; hs <= hs + 1;
      end
   end

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   int n_tests = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic pulse_go();
      go = 1'b1; @(negedge clk); go = 1'b0;
   endtask

   task automatic wait_hs(input int target, input int max, input string name);
      int n = 0;
      while (hs < target && n < max) begin @(negedge clk); n++; end
      chk(name, 32'(hs >= target), 32'd1);
   endtask

   task automatic wait_done(input int max, input string name, output logic busy_before);
      int n = 0;
      busy_before = busy;
      while (done !== 1'b1 && n < max) begin busy_before = busy; @(negedge clk); n++; end
      chk(name, 32'(done === 1'b1), 32'd1);
   endtask

   typedef struct { logic [4:0] addr; logic [7:0] exp; } rd_vec_t;
   rd_vec_t tbl [8];

   task automatic read_table(input string tag);
      for (int i = 0; i < 8; i++) begin
         rd_addr = tbl[i].addr;
         @(negedge clk);
         chk($sformatf("%s_rd%0d", tag, tbl[i].addr), 32'(rd_data), 32'(tbl[i].exp));
      end
   endtask

   initial begin
      logic bb;
      int   bad, cnt;
      tbl[0] = '{5'd0, 8'd0};   tbl[1] = '{5'd1, 8'd3};   tbl[2] = '{5'd2, 8'd6};
      tbl[3] = '{5'd7, 8'd21};  tbl[4] = '{5'd10, 8'd30}; tbl[5] = '{5'd24, 8'd72};
      tbl[6] = '{5'd25, 8'd0};  tbl[7] = '{5'd31, 8'd0};

      repeat (3) @(negedge clk);
      chk("reset_link", link_out, 32'd0);
      chk("reset_rd", 32'(rd_data), 32'd0);
      chk("reset_flags", 32'({busy, done, error}), 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 25; i++) begin
         wr_en = 1'b1; wr_addr = 5'(i); wr_a = 8'(i); wr_b = 8'(2*i);
         @(negedge clk);
      end
      wr_en = 1'b0;

      // nominal run, with an ignored go and an out-of-range write mid-transfer
      done_cnt = 0;
      pulse_go();
      wait_hs(3, 300, "run1_reach_hs3");
      op_code = 3'd5; matrix_size = 2'd1;
      wr_en = 1'b1; wr_addr = 5'd31; wr_a = 8'hff; wr_b = 8'hff; go = 1'b1;
      @(negedge clk);
      go = 1'b0; wr_en = 1'b0; op_code = 3'd3; matrix_size = 2'd2;
      @(negedge clk);
      chk("run1_fields", 32'(link_out[20:16]), 32'b10011);
      wait_done(20000, "run1_done", bb);
      chk("run1_busy_before_done", 32'(bb), 32'd1);
      @(negedge clk);
      chk("run1_after_done", 32'({busy, done}), 32'd0);
      repeat (5) @(negedge clk);
      chk("run1_done_pulses", done_cnt, 1);
      chk("run1_handshakes", hs, 51);
      chk("run1_error", 32'(error), 32'd0);
      bad = 0;
      for (int i = 0; i < 25; i++) if (ma[i] !== 8'(i) || mb[i] !== 8'(2*i)) bad++;
      chk("run1_tx_data", bad, 0);
      read_table("run1");

      // long processing phase stays in RX_RAISE without timing out
      proc_delay = 5000;
      pulse_go();
      wait_hs(25, 1000, "run2_reach_rx");
      repeat (2000) @(negedge clk);
      chk("run2_ready_held", 32'({link_out[31], busy, error}), 32'b110);
      wait_done(20000, "run2_done", bb);
      proc_delay = 10;
      repeat (2) @(negedge clk);
      chk("run2_handshakes", hs, 51);

      // stall ack at element 7 until timeout
      stall_hs = 7;
      pulse_go();
      cnt = 0;
      while (!(link_out[31] && link_out[7:0] == 8'd7) && cnt < 1000) begin @(negedge clk); cnt++; end
      chk("to_reach_idx7", 32'(link_out[31] && link_out[7:0] == 8'd7), 32'd1);
      cnt = 0;
      while (error !== 1'b1 && cnt < TO + 100) begin @(negedge clk); cnt++; end
      chk("to_cycles", cnt, TO);
      chk("to_link_zero", link_out, 32'd0);
      chk("to_busy", 32'(busy), 32'd0);
      stall_hs = 99;
      repeat (3) @(negedge clk);
      chk("to_error_sticky", 32'(error), 32'd1);
      pulse_go();
      chk("to_go_clears", 32'(error), 32'd0);
      cnt = 0;
      while (!link_out[31] && cnt < 100) begin @(negedge clk); cnt++; end
      chk("to_restart_idx0", 32'({link_out[31], link_out[15:0]}), 32'h10000);
      wait_done(20000, "to_restart_done", bb);

      // abort while settling result 10
      repeat (3) @(negedge clk);
      done_cnt = 0;
      pulse_go();
      wait_hs(36, 3000, "ab_reach_rx10");
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("ab_link1", link_out, 32'h2000_0000);
      @(negedge clk);
      chk("ab_link2", link_out, 32'h2000_0000);
      @(negedge clk);
      chk("ab_link_clear", link_out, 32'd0);
      chk("ab_busy", 32'(busy), 32'd0);
      repeat (20) @(negedge clk);
      chk("ab_no_done", done_cnt, 0);
      chk("ab_error", 32'(error), 32'd0);

      // asynchronous reset mid-TX, then a full rerun on the kept operands
      pulse_go();
      wait_hs(5, 500, "rst_reach_hs5");
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_async_link", link_out, 32'd0);
      chk("rst_async_flags", 32'({busy, done, error}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      repeat (5) @(negedge clk);
      pulse_go();
      wait_done(20000, "rst_rerun_done", bb);
      repeat (2) @(negedge clk);
      chk("rst_handshakes", hs, 51);
      read_table("rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
